adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters time-share one N-bit ripple adder for N- or 2N-bit add/sub.
// ripple_carry_adder_Nb inverts carry_i whenever inv_b_i is set, so carry_i=0 yields A-B.
module ripple_carry_adder_Nb #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         inv_b_i,
    input  logic         carry_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);
    logic [N:0]   c;
    logic [N-1:0] bx;
    assign bx   = b_i ^ {N{inv_b_i}};
    assign c[0] = carry_i ^ inv_b_i;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end
    assign carry_o = c[N];
endmodule

module adder_arbiter #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [2*N-1:0] req0_opa_i,
    input  logic [2*N-1:0] req0_opb_i,
    input  logic         req0_sub_i,
    input  logic         req0_wide_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [2*N-1:0] req1_opa_i,
    input  logic [2*N-1:0] req1_opb_i,
    input  logic         req1_sub_i,
    input  logic         req1_wide_i,
    output logic         rsp0_valid_o,
    output logic [2*N-1:0] rsp0_res_o,
    output logic         rsp0_carry_o,
    output logic         rsp0_ovf_o,
    output logic         rsp0_zero_o,
    output logic         rsp1_valid_o,
    output logic [2*N-1:0] rsp1_res_o,
    output logic         rsp1_carry_o,
    output logic         rsp1_ovf_o,
    output logic         rsp1_zero_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    state_t         state_q, state_d;
    logic [2*N-1:0] opa_q, opb_q;
    logic           sub_q, wide_q, port_q, last_q, c_lo_q;
    logic [N-1:0]   lo_q;
    logic [1:0]     rsp_valid_q, rsp_carry_q, rsp_ovf_q, rsp_zero_q;
    logic [2*N-1:0] rsp_res_q [2];
    logic           gnt0, gnt1, acc, hi, fin, cin, ovf_d, carry;
    logic [N-1:0]   a_s, b_s, sum;
    logic [2*N-1:0] res_d;
    // last_q names the port served most recently; the other port wins a tie
    assign gnt0 = (state_q == IDLE) & ~rst_i & req0_valid_i & (~req1_valid_i | last_q);
    assign gnt1 = (state_q == IDLE) & ~rst_i & req1_valid_i & (~req0_valid_i | ~last_q);
    assign acc  = gnt0 | gnt1;
    assign hi   = state_q == HI;
    assign fin  = hi | ((state_q == LO) & ~wide_q);
    assign a_s  = hi ? opa_q[2*N-1:N] : opa_q[N-1:0];
    assign b_s  = hi ? opb_q[2*N-1:N] : opb_q[N-1:0];
    assign cin  = hi & (sub_q ^ c_lo_q);
    ripple_carry_adder_Nb #(.N(N)) u_add (
        .a_i    (a_s),
        .b_i    (b_s),
        .inv_b_i(sub_q),
        .carry_i(cin),
        .sum_o  (sum),
        .carry_o(carry)
    );
    assign ovf_d = (a_s[N-1] == (b_s[N-1] ^ sub_q)) & (sum[N-1] != a_s[N-1]);
    assign res_d = hi ? {sum, lo_q} : {{N{1'b0}}, sum};
    always_comb begin
        state_d = state_q == IDLE ? (acc ? LO : IDLE) :
                  state_q == LO   ? (wide_q ? HI : IDLE) : IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            rsp_valid_q <= '0;
            rsp_carry_q <= '0;
            rsp_ovf_q   <= '0;
            rsp_zero_q  <= '0;
            rsp_res_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (acc) begin
                opa_q  <= gnt1 ? req1_opa_i : req0_opa_i;
                opb_q  <= gnt1 ? req1_opb_i : req0_opb_i;
                sub_q  <= gnt1 ? req1_sub_i : req0_sub_i;
                wide_q <= gnt1 ? req1_wide_i : req0_wide_i;
                port_q <= gnt1;
                last_q <= gnt1;
            end
            if (state_q == LO) begin
                lo_q   <= sum;
                c_lo_q <= carry;
            end
            if (fin) begin
                rsp_valid_q[port_q] <= 1'b1;
                rsp_res_q[port_q]   <= res_d;
                rsp_carry_q[port_q] <= carry;
                rsp_ovf_q[port_q]   <= ovf_d;
                rsp_zero_q[port_q]  <= ~|res_d;
            end
        end
    end
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign busy_o       = state_q != IDLE;
    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp0_res_o   = rsp_res_q[0];
    assign rsp1_res_o   = rsp_res_q[1];
    assign rsp0_carry_o = rsp_carry_q[0];
    assign rsp1_carry_o = rsp_carry_q[1];
    assign rsp0_ovf_o   = rsp_ovf_q[0];
    assign rsp1_ovf_o   = rsp_ovf_q[1];
    assign rsp0_zero_o  = rsp_zero_q[0];
    assign rsp1_zero_o  = rsp_zero_q[1];
endmodule
